// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU run sequencer: state encoding, default
// parameter values and a small constant helper for sizing the cycle counter.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    localparam int DEF_MODE_W       = 2;
    localparam int DEF_NUM_MODES    = 4;
    localparam int DEF_RESET_CYCLES = 10;
    localparam int DEF_RUN_CYCLES   = 90;
    localparam int DEF_DATA_W       = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; it parks at zero rather than
// wrapping, so a phase that outlives its count simply waits.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Steps a CPU through every mode: hold it in reset, let it run, capture its
// register, hand the result off, then advance to the next mode.
module cpu_run_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MODE_W       = DEF_MODE_W,
    parameter int NUM_MODES    = DEF_NUM_MODES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int RUN_CYCLES   = DEF_RUN_CYCLES,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] register,
    input  logic              result_ready,
    output logic [MODE_W-1:0] control,
    output logic              cpu_reset,
    output logic [DATA_W-1:0] result,
    output logic [MODE_W-1:0] result_mode,
    output logic              result_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max_int(RESET_CYCLES, RUN_CYCLES) + 1);
    // Counter is loaded with length-1 so the zero flag marks a phase's final cycle.
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LOAD  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    seq_state_e        state_q, state_d;
    logic [MODE_W-1:0] control_q, control_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [MODE_W-1:0] result_mode_q, result_mode_d;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_zero;

    seq_down_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_value),
        .zero_o     (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        control_d     = control_q;
        result_d      = result_q;
        result_mode_d = result_mode_q;
        cnt_load      = 1'b0;
        cnt_value     = HOLD_LOAD;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    control_d = '0;
                    state_d   = ST_HOLD;
                    cnt_load  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d   = ST_RUN;
                    cnt_load  = 1'b1;
                    cnt_value = RUN_LOAD;
                end
            end
            ST_RUN: begin
                if (cnt_zero) begin
                    state_d       = ST_CAPTURE;
                    result_d      = register;
                    result_mode_d = control_q;
                end
            end
            ST_CAPTURE: begin
                if (result_ready) begin
                    if (control_q == LAST_MODE) begin
                        state_d = ST_DONE;
                    end else begin
                        control_d = control_q + 1'b1;
                        state_d   = ST_HOLD;
                        cnt_load  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            control_q     <= '0;
            result_q      <= '0;
            result_mode_q <= '0;
        end else begin
            state_q       <= state_d;
            control_q     <= control_d;
            result_q      <= result_d;
            result_mode_q <= result_mode_d;
        end
    end

    // Status outputs decode the registered state, so reset reaches them at once.
    assign control      = control_q;
    assign result       = result_q;
    assign result_mode  = result_mode_q;
    assign cpu_reset    = (state_q != ST_RUN);
    assign result_valid = (state_q == ST_CAPTURE);
    assign busy         = (state_q == ST_HOLD) || (state_q == ST_RUN) || (state_q == ST_CAPTURE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: walks whole sequences with random register data,
// random ready stalls and stray start pulses, plus a minimal-parameter instance.
module tb_cpu_run_sequencer;

    localparam int NM   = 4;
    localparam int RC   = 10;
    localparam int RUNC = 90;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] register;
    logic       result_ready;
    logic [1:0] control;
    logic       cpu_reset;
    logic [7:0] result;
    logic [1:0] result_mode;
    logic       result_valid;
    logic       busy;
    logic       done;

    logic       start1;
    logic [7:0] register1;
    logic       result_ready1;
    logic [1:0] control1;
    logic       cpu_reset1;
    logic [7:0] result1;
    logic [1:0] result_mode1;
    logic       result_valid1;
    logic       busy1;
    logic       done1;

    int checks = 0;
    int errors = 0;
    bit aborted;

    always #5 clk = ~clk;

    cpu_run_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .register     (register),
        .result_ready (result_ready),
        .control      (control),
        .cpu_reset    (cpu_reset),
        .result       (result),
        .result_mode  (result_mode),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    cpu_run_sequencer #(
        .NUM_MODES    (1),
        .RESET_CYCLES (1),
        .RUN_CYCLES   (1)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start1),
        .register     (register1),
        .result_ready (result_ready1),
        .control      (control1),
        .cpu_reset    (cpu_reset1),
        .result       (result1),
        .result_mode  (result_mode1),
        .result_valid (result_valid1),
        .busy         (busy1),
        .done         (done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " control"},      32'(control),      0);
        check({tag, " cpu_reset"},    32'(cpu_reset),    1);
        check({tag, " result"},       32'(result),       0);
        check({tag, " result_mode"},  32'(result_mode),  0);
        check({tag, " result_valid"}, 32'(result_valid), 0);
        check({tag, " busy"},         32'(busy),         0);
        check({tag, " done"},         32'(done),         0);
    endtask

    // Entered one negedge after the start edge; expects mode m to hold the CPU in
    // reset for RC cycles, run it for RUNC cycles, then offer one captured result.
    task automatic run_seq(input int abort_mode, output bit was_aborted);
        logic [7:0] exp_result;
        int         stalls;
        was_aborted = 1'b0;
        exp_result  = '0;
        for (int m = 0; m < NM; m++) begin
            for (int i = 0; i < RC; i++) begin
                check("hold cpu_reset", 32'(cpu_reset), 1);
                check("hold busy", 32'(busy), 1);
                check("hold done", 32'(done), 0);
                check("hold control", 32'(control), 32'(m));
                check("hold result_valid", 32'(result_valid), 0);
                start    = 1'($urandom_range(0, 1));
                register = 8'($urandom);
                @(negedge clk);
            end
            for (int i = 0; i < RUNC; i++) begin
                check("run cpu_reset", 32'(cpu_reset), 0);
                check("run control", 32'(control), 32'(m));
                check("run result_valid", 32'(result_valid), 0);
                start    = 1'($urandom_range(0, 1));
                register = (m == 2 && i == RUNC - 1) ? 8'hA5 : 8'($urandom);
                if (i == RUNC - 1) exp_result = register;
                if (m == abort_mode && i == RUNC / 2) begin
                    start = 1'b0;
                    #2 reset = 1'b1;
                    #1 check_reset_values("async reset");
                    @(negedge clk);
                    check_reset_values("held reset");
                    reset = 1'b0;
                    was_aborted = 1'b1;
                    return;
                end
                @(negedge clk);
            end
            stalls = (m == 1) ? 7 : $urandom_range(0, 3);
            for (int s = 0; s <= stalls; s++) begin
                check("cap result_valid", 32'(result_valid), 1);
                check("cap result", 32'(result), 32'(exp_result));
                check("cap result_mode", 32'(result_mode), 32'(m));
                check("cap cpu_reset", 32'(cpu_reset), 1);
                check("cap control", 32'(control), 32'(m));
                result_ready = (s == stalls);
                start        = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            result_ready = 1'b1;
        end
        start = 1'b0;
        check("end done", 32'(done), 1);
        check("end busy", 32'(busy), 0);
        check("end result_valid", 32'(result_valid), 0);
        check("end cpu_reset", 32'(cpu_reset), 1);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        register      = '0;
        result_ready  = 1'b1;
        start1        = 1'b0;
        register1     = '0;
        result_ready1 = 1'b1;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        // First sequence from IDLE.
        start = 1'b1;
        @(negedge clk);
        run_seq(-1, aborted);

        // DONE stays put until start.
        repeat (2) begin
            @(negedge clk);
            check("done hold", 32'(done), 1);
        end

        // Restart from DONE runs again from mode 0.
        start = 1'b1;
        @(negedge clk);
        run_seq(-1, aborted);

        // Reset during RUN of mode 1, then require start again.
        start = 1'b1;
        @(negedge clk);
        run_seq(1, aborted);
        check("aborted", 32'(aborted), 1);
        repeat (3) begin
            @(negedge clk);
            check_reset_values("post-abort idle");
        end
        start = 1'b1;
        @(negedge clk);
        run_seq(-1, aborted);

        // Minimal instance: one HOLD, one RUN, one result, then DONE.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("min hold cpu_reset", 32'(cpu_reset1), 1);
        check("min hold busy", 32'(busy1), 1);
        register1 = 8'h3C;
        @(negedge clk);
        check("min run cpu_reset", 32'(cpu_reset1), 0);
        check("min run result_valid", 32'(result_valid1), 0);
        @(negedge clk);
        check("min cap result_valid", 32'(result_valid1), 1);
        check("min cap result", 32'(result1), 32'h3C);
        check("min cap result_mode", 32'(result_mode1), 0);
        @(negedge clk);
        check("min done", 32'(done1), 1);
        check("min busy", 32'(busy1), 0);
        check("min result_valid", 32'(result_valid1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_sequencer.md
CPU_RUN_SEQUENCER -- requirements
Module: cpu_run_sequencer

Interface
REQ-001 SHALL have parameter MODE_W, default 2: width of the CPU control/mode word.
REQ-002 SHALL have parameter NUM_MODES, default 4: number of modes run per sequence, legal range 1..2**MODE_W.
REQ-003 SHALL have parameter RESET_CYCLES, default 10: cycles the CPU is held in reset per mode, minimum 1.
REQ-004 SHALL have parameter RUN_CYCLES, default 90: cycles the CPU runs per mode, minimum 1.
REQ-005 SHALL have parameter DATA_W, default 8: width of the observed CPU register output.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: begins a sequence when sampled high in IDLE or DONE.
REQ-009 SHALL have port register, input, DATA_W: observed CPU register value.
REQ-010 SHALL have port result_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port control, output, MODE_W: mode word driven to the CPU.
REQ-012 SHALL have port cpu_reset, output, 1: reset driven to the CPU, active-high.
REQ-013 SHALL have port result, output, DATA_W: captured register value.
REQ-014 SHALL have port result_mode, output, MODE_W: mode that produced result.
REQ-015 SHALL have port result_valid, output, 1: result, result_mode valid.
REQ-016 SHALL have port busy, output, 1: high in HOLD, RUN and CAPTURE.
REQ-017 SHALL have port done, output, 1: high in DONE only.

Function
REQ-018 SHALL implement the states IDLE, HOLD, RUN, CAPTURE and DONE.
REQ-019 IDLE/DONE: cpu_reset=1; on start=1, control<=0 and the next state is HOLD; start is ignored while busy.
REQ-020 HOLD SHALL last exactly RESET_CYCLES cycles with cpu_reset=1, then go to RUN.
REQ-021 RUN SHALL last exactly RUN_CYCLES cycles with cpu_reset=0; on the clock edge ending the last RUN cycle, result<=register and result_mode<=control, and the state goes to CAPTURE.
REQ-022 CAPTURE: result_valid=1, cpu_reset=1, and result/result_mode SHALL be held stable until result_valid&&result_ready.
REQ-023 A transfer SHALL occur in any cycle where result_valid&&result_ready; with result_ready already high, CAPTURE SHALL last exactly 1 cycle.
REQ-024 On transfer: if control==NUM_MODES-1, the next state SHALL be DONE; otherwise control<=control+1 and the next state SHALL be HOLD.
REQ-025 control SHALL change only on the start edge or on a transfer edge, and never while cpu_reset=0.
REQ-026 The cycle counter SHALL be $clog2(max(RESET_CYCLES,RUN_CYCLES)+1) bits wide, load on state entry, and count down with no wrap.
REQ-027 NUM_MODES=1: the sequence SHALL be one HOLD/RUN/CAPTURE pass, then DONE.
REQ-028 With start high in DONE, the sequencer SHALL restart at mode 0 and deassert done on the next cycle.

Reset
REQ-029 While reset=1, regardless of clk: state=IDLE, control=0, cpu_reset=1, result=0, result_mode=0, result_valid=0, busy=0, done=0, counter=0.
REQ-030 Reset asserted mid-sequence SHALL abort immediately with no partial result emitted; after release, start is required to begin again.

Structure
REQ-031 A shared package cpu_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-032 A single sub-module, seq_down_counter (loadable down-counter with a zero flag), SHALL be used for the HOLD/RUN timing.

Verification
REQ-033 With defaults and result_ready=1: pulse start -> per mode, cpu_reset high 10 cycles then low 90, control 0,1,2,3, and 4 result_valid pulses of 1 cycle each, then done=1.
REQ-034 Drive register=8'hA5 in the last RUN cycle of mode 2 -> result=8'hA5, result_mode=2.
REQ-035 Hold result_ready=0 for 7 cycles in CAPTURE -> result_valid stays high with result stable, cpu_reset=1, control unchanged; transfer on the first ready cycle.
REQ-036 Assert reset during RUN of mode 1 -> outputs take their reset values within the same cycle, no result_valid, and start then runs from mode 0.
REQ-037 Pulse start while busy -> no effect; pulse start in DONE -> a new sequence runs from mode 0.
REQ-038 With NUM_MODES=1, RESET_CYCLES=1, RUN_CYCLES=1 -> one HOLD cycle, one RUN cycle, one result, then DONE.
